// File: rtl/seq_det_ctrl_pkg.sv
// rtl/seq_det_ctrl_pkg.sv - shared encodings, default widths and detector next-state function
//   Controller states: C_IDLE, C_SHIFT, C_DRAIN.
//   Detector states:   D_IDLE (3'b000) .. D_S0101 (3'b100).
package seq_det_ctrl_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    C_IDLE  = 2'd0,
    C_SHIFT = 2'd1,
    C_DRAIN = 2'd2
  } ctrl_state_e;

  typedef enum logic [2:0] {
    D_IDLE  = 3'b000,
    D_S0    = 3'b001,
    D_S01   = 3'b010,
    D_S010  = 3'b011,
    D_S0101 = 3'b100
  } det_state_e;

  // Overlapping "0101" transition table; after a full match the "010"
  // suffix is retained so back-to-back matches share two bits.
  function automatic det_state_e det_next(input det_state_e s, input logic din);
    case (s)
      D_IDLE:  return din ? D_IDLE  : D_S0;
      D_S0:    return din ? D_S01   : D_S0;
      D_S01:   return din ? D_IDLE  : D_S010;
      D_S010:  return din ? D_S0101 : D_S0;
      D_S0101: return din ? D_IDLE  : D_S010;
      default: return D_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/seq_det_ctrl_det0101_en.sv
// rtl/seq_det_ctrl_det0101_en.sv - gated Moore detector for overlapping "0101"
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset to D_IDLE
//   en    : advance one state on this edge
//   clr   : synchronous return to D_IDLE (wins over en)
//   din   : serial bit
//   match : high while the state is D_S0101
module det0101_en
  import seq_det_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic din,
  output logic match
);

  det_state_e state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= D_IDLE;
    end else if (clr) begin
      state_q <= D_IDLE;
    end else if (en) begin
      state_q <= det_next(state_q, din);
    end
  end

  assign match = (state_q == D_S0101);

endmodule

// File: rtl/seq_det_ctrl.sv
// rtl/seq_det_ctrl.sv - word-stream controller feeding a gated "0101" detector
//   in_valid/in_ready/in_data : word handshake, MSB shifted first
//   flush                     : return detector to D_IDLE, honoured only while idle
//   thr/irq_clr/irq           : sticky threshold interrupt on total_hits (thr=0 disables)
//   busy                      : word in flight
//   word_done/word_hits       : one-cycle pulse with the hit count of the finished word
//   total_hits                : saturating hit count since reset
module seq_det_ctrl
  import seq_det_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  input  logic [CNT_W-1:0] thr,
  input  logic             irq_clr,
  output logic             busy,
  output logic             word_done,
  output logic [CNT_W-1:0] word_hits,
  output logic [CNT_W-1:0] total_hits,
  output logic             irq
);

  localparam int               BCW      = $clog2(WIDTH);
  localparam logic [BCW-1:0]   LAST_BIT = BCW'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  ctrl_state_e      state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [BCW-1:0]   bitcnt_q;
  logic             adv_q;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] word_hits_q;
  logic [CNT_W-1:0] total_q, total_d;
  logic             irq_q, irq_d;
  logic             word_done_q;
  logic             in_ready_q;
  logic             busy_q;

  logic det_en, det_din, det_clr, det_match, hit;

  assign det_en  = (state_q == C_SHIFT);
  assign det_din = shreg_q[WIDTH-1];
  assign det_clr = flush && (state_q == C_IDLE);

  det0101_en u_det (
    .clk   (clk),
    .rst   (rst),
    .en    (det_en),
    .clr   (det_clr),
    .din   (det_din),
    .match (det_match)
  );

  // match is only fresh on the cycle after an enabled edge, so a held
  // D_S0101 (en low) is not counted twice.
  assign hit = det_match && adv_q;

  always_comb begin
    acc_d   = acc_q;
    total_d = total_q;
    irq_d   = irq_q;
    if (hit && (state_q != C_IDLE) && (acc_q != CNT_MAX)) acc_d = acc_q + CNT_W'(1);
    if (hit && (total_q != CNT_MAX)) total_d = total_q + CNT_W'(1);
    if (irq_clr) irq_d = 1'b0;
    // Set is evaluated last so it wins over a simultaneous clear.
    if ((thr != '0) && (total_q >= thr)) irq_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= C_IDLE;
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      adv_q       <= 1'b0;
      acc_q       <= '0;
      word_hits_q <= '0;
      total_q     <= '0;
      irq_q       <= 1'b0;
      word_done_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      word_done_q <= 1'b0;
      adv_q       <= det_en;
      total_q     <= total_d;
      irq_q       <= irq_d;
      case (state_q)
        C_IDLE: begin
          if (in_valid) begin
            shreg_q    <= in_data;
            bitcnt_q   <= LAST_BIT;
            acc_q      <= '0;
            state_q    <= C_SHIFT;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        C_SHIFT: begin
          shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
          acc_q   <= acc_d;
          if (bitcnt_q == '0) begin
            state_q <= C_DRAIN;
          end else begin
            bitcnt_q <= bitcnt_q - BCW'(1);
          end
        end
        C_DRAIN: begin
          // The last bit's hit shows up here and still belongs to this word.
          acc_q       <= acc_d;
          word_hits_q <= acc_d;
          word_done_q <= 1'b1;
          state_q     <= C_IDLE;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q    <= C_IDLE;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign word_done  = word_done_q;
  assign word_hits  = word_hits_q;
  assign total_hits = total_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb/tb_seq_det_ctrl.sv - self-checking bench for seq_det_ctrl
module tb_seq_det_ctrl;
  import seq_det_ctrl_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             flush = 1'b0;
  logic [CNT_W-1:0] thr = '0;
  logic             irq_clr = 1'b0;
  logic             in_ready, busy, word_done, irq;
  logic [CNT_W-1:0] word_hits, total_hits;

  seq_det_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .flush      (flush),
    .thr        (thr),
    .irq_clr    (irq_clr),
    .busy       (busy),
    .word_done  (word_done),
    .word_hits  (word_hits),
    .total_hits (total_hits),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: the last four stream bits since reset/flush; a hit is any
  // position where those four bits read 0101.
  logic [3:0] m_hist;
  int         m_nbits;
  int         m_total;
  bit         m_irq;

  bit         irq_seen_busy;
  logic [7:0] total_at_irq;

  typedef struct {
    logic [7:0] data;
    bit         flush_first;
    int         exp_hits;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_word(input logic [7:0] d, output int hits);
    hits = 0;
    for (int b = 7; b >= 0; b--) begin
      m_hist = {m_hist[2:0], d[b]};
      if (m_nbits < 4) m_nbits++;
      if (m_nbits == 4 && m_hist == 4'b0101) hits++;
    end
    m_total = m_total + hits;
    if (m_total > 255) m_total = 255;
  endtask

  function automatic bit irq_cond();
    return (thr != 0) && (m_total >= int'(thr));
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_hist = '0; m_nbits = 0; m_total = 0; m_irq = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    m_hist = '0; m_nbits = 0;
  endtask

  // Sends one word, waits for word_done, then checks latency, word_hits,
  // and (one cycle later) total_hits and irq. exp_hits < 0 uses the model.
  task automatic run_word(input string tag, input logic [7:0] d, input int flush_at, input int exp_hits);
    int  lat;
    bit  done;
    int  mh;
    model_word(d, mh);
    if (exp_hits < 0) exp_hits = mh;
    irq_seen_busy = 1'b0;
    check({tag, "_ready"}, in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    lat  = 1;
    done = 1'b0;
    while (!done && lat <= WIDTH + 6) begin
      if (irq && busy && !irq_seen_busy) begin
        irq_seen_busy = 1'b1;
        total_at_irq  = total_hits;
      end
      if (word_done) begin
        done = 1'b1;
      end else begin
        flush = (lat == flush_at);
        @(negedge clk);
        flush = 1'b0;
        lat++;
      end
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: got no word_done expected word_done within %0d cycles", tag, WIDTH + 6);
    end else begin
      check({tag, "_latency"}, lat, WIDTH + 2);
      check({tag, "_word_hits"}, word_hits, exp_hits);
      check({tag, "_ready_at_done"}, in_ready, 1);
    end
    @(negedge clk);
    if (irq_cond()) m_irq = 1'b1;
    check({tag, "_total"}, total_hits, m_total);
    check({tag, "_irq"}, irq, m_irq);
  endtask

  initial begin
    int r;
    int wd_cnt;

    tbl[0]  = '{8'h55, 1'b1, 3};
    tbl[1]  = '{8'hFF, 1'b1, 0};
    tbl[2]  = '{8'h00, 1'b0, 0};
    tbl[3]  = '{8'h02, 1'b1, 0};
    tbl[4]  = '{8'h80, 1'b0, 1};
    tbl[5]  = '{8'h02, 1'b1, 0};
    tbl[6]  = '{8'h80, 1'b1, 0};
    tbl[7]  = '{8'h55, 1'b1, 3};
    tbl[8]  = '{8'h55, 1'b0, 4};
    tbl[9]  = '{8'hAA, 1'b1, 2};
    tbl[10] = '{8'h0A, 1'b1, 1};

    // Reset state
    do_reset();
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_word_done", word_done, 0);
    check("rst_word_hits", word_hits, 0);
    check("rst_total", total_hits, 0);
    check("rst_irq", irq, 0);

    // Directed table
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].flush_first) do_flush();
      run_word($sformatf("tbl%0d", i), tbl[i].data, 0, tbl[i].exp_hits);
      if (i == 2) check("no_hits_det_state", dut.u_det.state_q, D_S0);
    end

    // Threshold and irq
    do_reset();
    thr = 8'd4;
    do_flush();
    run_word("thr_w1", 8'h55, 0, 3);
    check("thr_irq_low_after_w1", irq, 0);
    do_flush();
    run_word("thr_w2", 8'h55, 0, 3);
    check("thr_irq_rose_busy", irq_seen_busy, 1);
    check("thr_total_at_rise", total_at_irq >= 8'd4, 1);
    check("thr_total_end", total_hits, 6);
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    check("thr_clr_set_wins", irq, 1);
    thr = 8'd0;
    @(negedge clk);
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    m_irq = 1'b0;
    check("thr_clr_disabled", irq, 0);

    // Saturation
    do_reset();
    for (int i = 0; i < 90; i++) begin
      do_flush();
      run_word("sat", 8'h55, 0, 3);
    end
    check("sat_total", total_hits, 255);

    // Randomized against the model
    do_reset();
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 7);
      if (r == 0) begin
        do_flush();
      end else if (r == 1) begin
        thr = 8'($urandom_range(0, 60));
        @(negedge clk);
        if (irq_cond()) m_irq = 1'b1;
      end else if (r == 2) begin
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        m_irq = irq_cond();
      end
      run_word("rand", 8'($urandom), 0, -1);
    end

    // Reset mid-word
    in_valid = 1'b1;
    in_data  = 8'h55;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_total", total_hits, 0);
    check("midrst_word_hits", word_hits, 0);
    check("midrst_irq", irq, 0);
    @(negedge clk);
    rst = 1'b0;
    thr = 8'd0;
    m_hist = '0; m_nbits = 0; m_total = 0; m_irq = 1'b0;
    wd_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (word_done) wd_cnt++;
      @(negedge clk);
    end
    check("midrst_no_word_done", wd_cnt, 0);

    // Flush during C_SHIFT must be ignored
    do_flush();
    run_word("flush_busy", 8'h55, 4, 3);
    run_word("flush_busy2", 8'h55, 6, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_det_ctrl.md
# seq_det_ctrl

Word-stream controller for the overlapping "0101" serial pattern detector. It accepts parallel words from a requester over a valid/ready handshake and shifts each word MSB-first, one bit per clock, into a gated Moore detector. It counts detector hits per word and in total, and raises a sticky threshold interrupt. It sits between a bus-side producer and the serial detection datapath, sequencing the detector so that the detector's match history carries across word boundaries.

## Interface
Parameters:
- WIDTH, 8, bits per input word (≥4)
- CNT_W, 8, width of word_hits, total_hits and thr

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous and active-high
- in_valid  in  1  word offered
- in_ready  out  1  controller can accept a word
- in_data  in  WIDTH  word, MSB shifted first
- flush  in  1  return detector to IDLE (honoured only while controller IDLE)
- thr  in  CNT_W  interrupt threshold; 0 disables irq
- irq_clr  in  1  clear irq
- busy  out  1  word in flight
- word_done  out  1  one-cycle pulse; word_hits valid
- word_hits  out  CNT_W  hits attributed to last completed word (held)
- total_hits  out  CNT_W  saturating hit count since reset
- irq  out  1  sticky: total_hits ≥ thr, thr≠0

## Operation
- Controller FSM has three states:
  - C_IDLE: in_ready=1. On in_valid, latch in_data into the shift register, load bit counter = WIDTH-1, and go to C_SHIFT.
  - C_SHIFT: drive detector din = shreg[WIDTH-1] and en=1, then shift left. When counter = 0, go to C_DRAIN; otherwise decrement the counter.
  - C_DRAIN: en=0, one cycle. Return to C_IDLE.
- Detector is a Moore machine with states D_IDLE, D_S0, D_S01, D_S010 and D_S0101. It advances only on an edge where en=1. Transitions on din:
  - D_IDLE: 0→D_S0, 1→D_IDLE
  - D_S0: 0→D_S0, 1→D_S01
  - D_S01: 0→D_S010, 1→D_IDLE
  - D_S010: 0→D_S0, 1→D_S0101
  - D_S0101: 0→D_S010, 1→D_IDLE
  - match = (state == D_S0101).
- Hit rule: hit = match && adv_q, where adv_q is en registered one cycle. A held D_S0101 state is therefore counted once only.
- The word hit accumulator clears on accept and increments on each hit during C_SHIFT/C_DRAIN. The hit seen in C_DRAIN belongs to the current word.
- word_hits ← accumulator value including any C_DRAIN hit. It is registered with the word_done pulse.
- total_hits increments on every hit and saturates at 2^CNT_W-1.
- irq sets on any cycle where thr≠0 and total_hits ≥ thr. irq_clr clears it. Simultaneous set and clear: set wins.
- flush while in C_IDLE forces the detector to D_IDLE on the next edge. flush in any other state is ignored.
- Without flush, the detector state persists across words, so patterns spanning a word boundary are detected.
- busy = (state ≠ C_IDLE).

## Timing
- Reset values:
  - Controller C_IDLE, detector D_IDLE.
  - in_ready=1, busy=0, word_done=0.
  - word_hits=0, total_hits=0, irq=0, shreg=0, adv_q=0.
- Accept occurs on edge E0, when in_valid && in_ready.
- Bits are consumed on edges E1..EWIDTH, then C_DRAIN runs during the cycle after EWIDTH.
- word_done and in_ready are both high in the cycle after edge EWIDTH+1.
- Latency is WIDTH+2 cycles from accept to word_done. Throughput is one word per WIDTH+2 cycles, and back-to-back accept is allowed in the word_done cycle.
- The producer must hold in_data stable only in the accept cycle.
- Reset asserted mid-word discards the in-flight word with no word_done. All counters and irq clear.

## Structure
- Shared package: controller state encoding (C_IDLE, C_SHIFT, C_DRAIN), detector state encoding (D_IDLE=3'b000 through D_S0101=3'b100), and the default widths.
- One sub-module, det0101_en: the gated Moore detector (clk, rst, en, din, match). It is instantiated once in seq_det_ctrl.

## Test plan
All scenarios use WIDTH=8 and CNT_W=8.
- **Reset:** reset asserted → in_ready=1, busy=0, all counters 0, irq=0. Then send 0x55 → word_done 10 cycles after accept, word_hits=3, total_hits=3.
- **No hits:** 0xFF, then 0x00 → word_hits 0, then 0. Detector ends in D_S0 and total_hits stays 0.
- **Cross-word match:** 0x02 then 0x80 with no flush → word_hits 0, then 1. Repeat with flush between the words → word_hits 0 and 0.
- **Threshold and irq:** thr=4; send 0x55, 0x55 → irq rises during the second word, when total_hits reaches 4, and ends at total_hits 6. Assert irq_clr while total_hits ≥ thr → irq stays 1. Set thr=0, then irq_clr → irq=0.
- **Saturation:** send 0x55 ninety times → total_hits saturates at 255 with no wrap to 14.
- **Reset mid-word and flush while busy:** assert rst 4 cycles after accepting 0x55 → no word_done, counters 0. In a separate run, flush pulsed during C_SHIFT is ignored and word_hits is unchanged.
